// File: rtl/imuldiv_muldiv_dispatch.sv
// Dispatch stage for the iterative mul/div units: steers each request to its unit,
// records issue order in a small tag FIFO, and merges unit responses back in order.
module imuldiv_muldiv_dispatch #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [2:0]  req_msg_fn,
    input  logic [31:0] req_msg_a,
    input  logic [31:0] req_msg_b,
    input  logic        req_val,
    output logic        req_rdy,

    output logic [31:0] mulreq_msg_a,
    output logic [31:0] mulreq_msg_b,
    output logic        mulreq_val,
    input  logic        mulreq_rdy,

    input  logic [63:0] mulresp_msg_result,
    input  logic        mulresp_val,
    output logic        mulresp_rdy,

    output logic [1:0]  divreq_msg_fn,
    output logic [31:0] divreq_msg_a,
    output logic [31:0] divreq_msg_b,
    output logic        divreq_val,
    input  logic        divreq_rdy,

    input  logic [63:0] divresp_msg_result,
    input  logic        divresp_val,
    output logic        divresp_rdy,

    output logic [63:0] resp_msg_result,
    output logic        resp_val,
    input  logic        resp_rdy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        TAG_MUL = 2'd0,
        TAG_DIV = 2'd1,
        TAG_ILL = 2'd2
    } tag_e;

    tag_e          fifo_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW:0]   count_q, count_d;

    tag_e req_tag;
    tag_e head_tag;
    logic full, empty;
    logic push, pop;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign head_tag = fifo_q[rptr_q];

    always_comb begin
        req_tag = TAG_ILL;
        case (req_msg_fn)
            3'd0:                      req_tag = TAG_MUL;
            3'd1, 3'd2, 3'd3, 3'd4:    req_tag = TAG_DIV;
            default:                   req_tag = TAG_ILL;
        endcase
    end

    assign mulreq_msg_a  = req_msg_a;
    assign mulreq_msg_b  = req_msg_b;
    assign divreq_msg_a  = req_msg_a;
    assign divreq_msg_b  = req_msg_b;
    assign divreq_msg_fn = req_msg_fn[1:0] - 2'd1;

    // Request side looks only at FIFO state, never at resp_rdy, so a pop
    // cannot make room for a push in the same cycle.
    always_comb begin
        req_rdy    = 1'b0;
        mulreq_val = 1'b0;
        divreq_val = 1'b0;
        if (!reset && !full) begin
            case (req_tag)
                TAG_MUL: begin
                    req_rdy    = mulreq_rdy;
                    mulreq_val = req_val;
                end
                TAG_DIV: begin
                    req_rdy    = divreq_rdy;
                    divreq_val = req_val;
                end
                default: req_rdy = 1'b1;
            endcase
        end
    end

    always_comb begin
        resp_val        = 1'b0;
        resp_msg_result = '0;
        mulresp_rdy     = 1'b0;
        divresp_rdy     = 1'b0;
        if (!reset && !empty) begin
            case (head_tag)
                TAG_MUL: begin
                    resp_val        = mulresp_val;
                    resp_msg_result = mulresp_msg_result;
                    mulresp_rdy     = resp_rdy;
                end
                TAG_DIV: begin
                    resp_val        = divresp_val;
                    resp_msg_result = divresp_msg_result;
                    divresp_rdy     = resp_rdy;
                end
                default: resp_val = 1'b1;
            endcase
        end
    end

    assign push = req_val && req_rdy;
    assign pop  = resp_val && resp_rdy;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + PW'(1);
        if (pop)  rptr_d = rptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= req_tag;
    end

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
// Scoreboard bench for imuldiv_muldiv_dispatch with behavioural mul/div unit models.
module tb_imuldiv_muldiv_dispatch;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_msg_fn;
    logic [31:0] req_msg_a, req_msg_b;
    logic        req_val, req_rdy;
    logic [31:0] mulreq_msg_a, mulreq_msg_b;
    logic        mulreq_val, mulreq_rdy;
    logic [63:0] mulresp_msg_result;
    logic        mulresp_val, mulresp_rdy;
    logic [1:0]  divreq_msg_fn;
    logic [31:0] divreq_msg_a, divreq_msg_b;
    logic        divreq_val, divreq_rdy;
    logic [63:0] divresp_msg_result;
    logic        divresp_val, divresp_rdy;
    logic [63:0] resp_msg_result;
    logic        resp_val, resp_rdy;

    always #5 clk = ~clk;

    imuldiv_muldiv_dispatch #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .req_msg_fn(req_msg_fn), .req_msg_a(req_msg_a), .req_msg_b(req_msg_b),
        .req_val(req_val), .req_rdy(req_rdy),
        .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b),
        .mulreq_val(mulreq_val), .mulreq_rdy(mulreq_rdy),
        .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val),
        .mulresp_rdy(mulresp_rdy),
        .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
        .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
        .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val),
        .divresp_rdy(divresp_rdy),
        .resp_msg_result(resp_msg_result), .resp_val(resp_val), .resp_rdy(resp_rdy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] sb [$];
    logic rnd_rdy_en = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] golden(input logic [2:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa, sb64;
        logic [31:0] r;
        sa   = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        case (fn)
            3'd0:    return sa * sb64;
            3'd1:    r = $signed(a) / $signed(b);
            3'd2:    r = a / b;
            3'd3:    r = $signed(a) % $signed(b);
            3'd4:    r = a % b;
            default: return 64'd0;
        endcase
        return {32'd0, r};
    endfunction

    // Multiplier model: one request in flight, result after a random delay.
    int unsigned mul_dmin = 0, mul_dmax = 3;
    logic        m_busy = 1'b0, m_val = 1'b0;
    logic [63:0] m_res = '0;
    int unsigned m_cnt = 0;
    assign mulreq_rdy         = !m_busy;
    assign mulresp_val        = m_val;
    assign mulresp_msg_result = m_res;

    initial begin
        logic rst_s, acc, pop;
        logic [31:0] a_s, b_s;
        forever begin
            @(negedge clk);
            rst_s = reset;
            acc   = mulreq_val && mulreq_rdy;
            pop   = mulresp_val && mulresp_rdy;
            a_s   = mulreq_msg_a;
            b_s   = mulreq_msg_b;
            @(posedge clk);
            #1;
            if (rst_s) begin
                m_busy = 1'b0;
                m_val  = 1'b0;
            end else begin
                if (pop) begin
                    m_busy = 1'b0;
                    m_val  = 1'b0;
                end else if (m_busy && !m_val) begin
                    if (m_cnt == 0) m_val = 1'b1;
                    else m_cnt--;
                end
                if (acc) begin
                    m_busy = 1'b1;
                    m_res  = 64'(longint'($signed(a_s)) * longint'($signed(b_s)));
                    m_cnt  = $urandom_range(mul_dmax, mul_dmin);
                end
            end
        end
    end

    // Divider model, keyed by its own 2-bit function code.
    int unsigned div_dmin = 0, div_dmax = 3;
    logic        d_busy = 1'b0, d_val = 1'b0;
    logic [63:0] d_res = '0;
    int unsigned d_cnt = 0;
    assign divreq_rdy         = !d_busy;
    assign divresp_val        = d_val;
    assign divresp_msg_result = d_res;

    initial begin
        logic rst_s, acc, pop;
        logic [31:0] a_s, b_s, r;
        logic [1:0] f_s;
        forever begin
            @(negedge clk);
            rst_s = reset;
            acc   = divreq_val && divreq_rdy;
            pop   = divresp_val && divresp_rdy;
            a_s   = divreq_msg_a;
            b_s   = divreq_msg_b;
            f_s   = divreq_msg_fn;
            @(posedge clk);
            #1;
            if (rst_s) begin
                d_busy = 1'b0;
                d_val  = 1'b0;
            end else begin
                if (pop) begin
                    d_busy = 1'b0;
                    d_val  = 1'b0;
                end else if (d_busy && !d_val) begin
                    if (d_cnt == 0) d_val = 1'b1;
                    else d_cnt--;
                end
                if (acc) begin
                    case (f_s)
                        2'd0: r = $signed(a_s) / $signed(b_s);
                        2'd1: r = a_s / b_s;
                        2'd2: r = $signed(a_s) % $signed(b_s);
                        default: r = a_s % b_s;
                    endcase
                    d_busy = 1'b1;
                    d_res  = {32'd0, r};
                    d_cnt  = $urandom_range(div_dmax, div_dmin);
                end
            end
        end
    end

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    initial begin
        logic [63:0] exp;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (req_val && req_rdy) sb.push_back(golden(req_msg_fn, req_msg_a, req_msg_b));
                if (resp_val && resp_rdy) begin
                    if (sb.size() == 0) begin
                        check_eq("sb_unexpected_resp", 64'(sb.size()), 64'd1);
                    end else begin
                        exp = sb.pop_front();
                        check_eq("resp", resp_msg_result, exp);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy_en) resp_rdy = 1'($urandom_range(1, 0));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        bit ok = 1'b0;
        req_msg_fn = fn;
        req_msg_a  = a;
        req_msg_b  = b;
        req_val    = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("send_timeout", 64'(req_rdy), 64'd1);
        step();
        req_val = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && dut.count_q == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("drain_timeout", 64'(sb.size()), 64'd0);
        step();
    endtask

    initial begin
        int stalls;
        bit div_done, mul_done;
        logic [2:0] fn;
        logic [31:0] a, b;

        reset = 1'b1; resp_rdy = 1'b1;
        req_val = 1'b1; req_msg_fn = 3'd0; req_msg_a = 32'd1; req_msg_b = 32'd2;
        step(); step();
        @(negedge clk);
        check_eq("rst_req_rdy",     64'(req_rdy),     64'd0);
        check_eq("rst_mulreq_val",  64'(mulreq_val),  64'd0);
        check_eq("rst_resp_val",    64'(resp_val),    64'd0);
        check_eq("rst_resp_result", resp_msg_result,  64'd0);
        check_eq("rst_unit_rdys",   64'({mulresp_rdy, divresp_rdy}), 64'd0);
        req_msg_fn = 3'd1;
        #1;
        check_eq("rst_divreq_val",  64'(divreq_val),  64'd0);
        step();
        reset = 1'b0; req_val = 1'b0;
        step();
        check_eq("post_rst_count", 64'(dut.count_q), 64'd0);

        // MUL 3 x -5 with operand passthrough
        mul_dmin = 2; mul_dmax = 2;
        req_msg_fn = 3'd0; req_msg_a = 32'd3; req_msg_b = 32'hFFFF_FFFB; req_val = 1'b1;
        @(negedge clk);
        check_eq("mul_req_val", 64'(mulreq_val), 64'd1);
        check_eq("mul_opa", 64'(mulreq_msg_a), 64'd3);
        check_eq("mul_opb", 64'(mulreq_msg_b), 64'hFFFF_FFFB);
        check_eq("mul_no_div", 64'(divreq_val), 64'd0);
        check_eq("mul_golden", golden(3'd0, 32'd3, 32'hFFFF_FFFB), 64'hFFFF_FFFF_FFFF_FFF1);
        step();
        req_val = 1'b0;
        drain();
        check_eq("mul_count0", 64'(dut.count_q), 64'd0);

        // DIV 100/7 then MUL 2x3; multiplier finishes first and must wait
        mul_dmin = 0; mul_dmax = 0; div_dmin = 6; div_dmax = 6;
        send(3'd1, 32'd100, 32'd7);
        send(3'd0, 32'd2, 32'd3);
        stalls = 0; div_done = 1'b0; mul_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mulresp_val && !div_done) begin
                check_eq("mul_stall_rdy", 64'(mulresp_rdy), 64'd0);
                stalls++;
            end
            if (divresp_val && divresp_rdy) begin
                check_eq("div_result", divresp_msg_result, 64'd14);
                div_done = 1'b1;
            end
            if (mulresp_val && mulresp_rdy) begin
                check_eq("mul_after_div", 64'(div_done), 64'd1);
                check_eq("mul_result", mulresp_msg_result, 64'd6);
                mul_done = 1'b1;
                break;
            end
        end
        check_eq("mul_done", 64'(mul_done), 64'd1);
        check_eq("mul_stalled", 64'(stalls > 0), 64'd1);
        drain();

        // Illegal function: no unit request, zero result the following cycle
        req_msg_fn = 3'd6; req_msg_a = 32'd1; req_msg_b = 32'd1; req_val = 1'b1;
        @(negedge clk);
        check_eq("ill_no_unit", 64'({mulreq_val, divreq_val}), 64'd0);
        check_eq("ill_accept", 64'(req_rdy), 64'd1);
        check_eq("ill_not_same_cycle", 64'(resp_val), 64'd0);
        step();
        req_val = 1'b0;
        @(negedge clk);
        check_eq("ill_resp_val", 64'(resp_val), 64'd1);
        check_eq("ill_result", resp_msg_result, 64'd0);
        drain();

        // Fill with ILL, then pop and push in the same cycle: push blocked
        resp_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send(3'd7, 32'(i), 32'd0);
        req_msg_fn = 3'd5; req_val = 1'b1;
        @(negedge clk);
        check_eq("full_blocks", 64'(req_rdy), 64'd0);
        step();
        resp_rdy = 1'b1;
        @(negedge clk);
        check_eq("full_pop_val", 64'(resp_val), 64'd1);
        check_eq("full_no_bypass", 64'(req_rdy), 64'd0);
        step();
        @(negedge clk);
        check_eq("after_pop_rdy", 64'(req_rdy), 64'd1);
        step();
        req_val = 1'b0;
        drain();

        // Reset with two requests outstanding
        mul_dmin = 10; mul_dmax = 10; div_dmin = 10; div_dmax = 10;
        send(3'd0, 32'd5, 32'd5);
        send(3'd2, 32'd9, 32'd3);
        check_eq("two_outstanding", 64'(dut.count_q), 64'd2);
        reset = 1'b1;
        sb.delete();
        step();
        reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_resp_val", 64'(resp_val), 64'd0);
        check_eq("midrst_count", 64'(dut.count_q), 64'd0);
        step();
        mul_dmin = 0; mul_dmax = 2; div_dmin = 0; div_dmax = 4;
        check_eq("mul44_golden", golden(3'd0, 32'd4, 32'd4), 64'd16);
        send(3'd0, 32'd4, 32'd4);
        drain();

        // Random mix with random backpressure and unit delays
        rnd_rdy_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            fn = 3'($urandom_range(7, 0));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(20, 0)) : $urandom;
            if (fn >= 3'd1 && fn <= 3'd4 && (b == 32'd0 || b == 32'hFFFF_FFFF)) b = 32'd7;
            send(fn, a, b);
            repeat ($urandom_range(1, 0)) step();
        end
        rnd_rdy_en = 1'b0;
        step();
        resp_rdy = 1'b1;
        drain();
        check_eq("end_sb_empty", 64'(sb.size()), 64'd0);
        check_eq("end_ptrs_equal", 64'(dut.wptr_q), 64'(dut.rptr_q));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
